// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and determinant datapath.
// Holds the packed-bus geometry, loader states and element offset mapping.
package matrix_pkg;

    localparam int ELEM_W   = 8;
    localparam int DIM      = 5;
    localparam int MATRIX_W = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } load_state_e;

    // Bit offset of element[row][col] in a packed dim x dim bus of ew-bit elements.
    function automatic int unsigned elem_off(
        input int unsigned row,
        input int unsigned col,
        input int unsigned dim,
        input int unsigned ew
    );
        return row * dim * ew + col * ew;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker for an N x N matrix.
// The column wraps at N-1 into the next row; last flags the final element.
module matrix_index_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          advance_i,
    input  logic [CW-1:0] n_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] n_last;

    assign n_last = n_i - CW'(1);

    // Next position: clear wins, otherwise step along the row and wrap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == n_last) begin
                col_d = '0;
                row_d = row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == n_last) && (col_q == n_last);

endmodule

// File: rtl/matrix_loader.sv
// Streams row-major elements into a zero-filled packed DIM x DIM matrix.
// Holds the finished matrix with matrix_valid until the consumer acks it.
module matrix_loader #(
    parameter int ELEM_W = matrix_pkg::ELEM_W,
    parameter int DIM    = matrix_pkg::DIM
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                size,
    input  logic                      in_valid,
    input  logic [ELEM_W-1:0]         in_data,
    output logic                      in_ready,
    output logic [DIM*DIM*ELEM_W-1:0] matrix_out,
    output logic                      matrix_valid,
    input  logic                      matrix_ack,
    output logic                      busy,
    output logic                      size_err
);

    import matrix_pkg::*;

    localparam int         MW   = DIM * DIM * ELEM_W;
    localparam int         OW   = $clog2(MW);
    localparam logic [2:0] DIM3 = 3'(DIM);

    load_state_e   state_q, state_d;
    logic [2:0]    n_q, n_d;
    logic [MW-1:0] mat_q, mat_d;
    logic          err_q, err_d;

    logic          cnt_clear;
    logic          cnt_adv;
    logic [2:0]    row_w, col_w;
    logic          last_w;
    logic [OW-1:0] off_w;

    matrix_index_counter #(.CW(3)) u_idx (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (cnt_clear),
        .advance_i (cnt_adv),
        .n_i       (n_q),
        .row_o     (row_w),
        .col_o     (col_w),
        .last_o    (last_w)
    );

    assign off_w = OW'(elem_off(32'(row_w), 32'(col_w), DIM, ELEM_W));

    // Next state, latched size, matrix write and error pulse.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        mat_d     = mat_q;
        err_d     = 1'b0;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (size != 3'd0 && size <= DIM3) begin
                        n_d       = size;
                        mat_d     = '0;
                        cnt_clear = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    cnt_adv = 1'b1;
                    mat_d[off_w +: ELEM_W] = in_data;
                    if (last_w) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (matrix_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            mat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            mat_q   <= mat_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == ST_LOAD);
    assign matrix_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign size_err     = err_q;
    assign matrix_out   = mat_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with a row-major element model.
// Outputs are compared every cycle; literals pin packing and latency.
module tb_matrix_loader;

    localparam int EW = 8;
    localparam int D  = 5;
    localparam int MW = D * D * EW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    size = 3'd0;
    logic          in_valid = 1'b0;
    logic [EW-1:0] in_data = '0;
    logic          matrix_ack = 1'b0;
    logic          in_ready;
    logic [MW-1:0] matrix_out;
    logic          matrix_valid;
    logic          busy;
    logic          size_err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    matrix_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .size         (size),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .matrix_out   (matrix_out),
        .matrix_valid (matrix_valid),
        .matrix_ack   (matrix_ack),
        .busy         (busy),
        .size_err     (size_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_m(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 holding; elements kept as a 2-D array.
    int          m_phase = 0;
    int          m_n     = 0;
    int          m_beats = 0;
    logic        m_err   = 1'b0;
    logic [7:0]  m_e [D][D];

    initial begin
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                m_e[r][c] = 8'h00;
    end

    always @(posedge clk) begin
        m_err <= 1'b0;
        if (reset) begin
            m_phase <= 0;
            m_n     <= 0;
            m_beats <= 0;
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++)
                    m_e[r][c] <= 8'h00;
        end else if (m_phase == 0) begin
            if (start) begin
                if (size >= 3'd1 && size <= 3'd5) begin
                    m_n     <= int'(size);
                    m_beats <= 0;
                    m_phase <= 1;
                    for (int r = 0; r < D; r++)
                        for (int c = 0; c < D; c++)
                            m_e[r][c] <= 8'h00;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_e[m_beats / m_n][m_beats % m_n] <= in_data;
                m_beats <= m_beats + 1;
                if (m_beats + 1 == m_n * m_n) m_phase <= 2;
            end
        end else begin
            if (matrix_ack) m_phase <= 0;
        end
    end

    function automatic logic [MW-1:0] packm();
        logic [MW-1:0] p = '0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                p = p | (MW'(m_e[r][c]) << (r * D * EW + c * EW));
        return p;
    endfunction

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk_b("in_ready", in_ready, m_phase == 1);
            chk_b("matrix_valid", matrix_valid, m_phase == 2);
            chk_b("busy", busy, m_phase != 0);
            chk_b("size_err", size_err, m_err);
            chk_m("matrix_out", matrix_out, packm());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input logic [7:0] v [25], input bit gap);
        int idx = 0;
        int k   = 1;
        while (idx < n * n && k < 100) begin
            in_valid = gap ? ((k % 2) == 1) : 1'b1;
            in_data  = v[idx];
            step();
            if (in_valid) idx++;
            k++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int s, input int exp_lat);
        int k = 0;
        while (!matrix_valid && k < 100) begin
            step();
            k++;
        end
        chk_b({tag, "_valid"}, matrix_valid, 1'b1);
        chk_m({tag, "_latency"}, MW'(cyc - s), MW'(exp_lat));
    endtask

    task automatic load(input int n, input logic [7:0] v [25], input bit gap,
                        input int exp_lat, input string tag);
        int s;
        start = 1'b1;
        size  = 3'(n);
        s     = cyc;
        step();
        start = 1'b0;
        feed(n, v, gap);
        wait_valid(tag, s, exp_lat);
    endtask

    task automatic ack();
        matrix_ack = 1'b1;
        step();
        matrix_ack = 1'b0;
    endtask

    function automatic int el(input int r, input int c);
        return int'(8'(matrix_out >> (r * D * EW + c * EW)));
    endfunction

    logic [7:0]    v [25];
    logic [MW-1:0] snap;
    int            det;

    initial begin
        repeat (2) step();
        reset = 1'b0;
        chk_m("rst_matrix", matrix_out, '0);
        chk_b("rst_busy", busy, 1'b0);

        for (int i = 0; i < 25; i++) v[i] = 8'(i + 1);
        load(3, v, 1'b0, 10, "t1");
        chk_m("t1_pack", matrix_out, 200'h09080700000605040000030201);
        ack();
        chk_b("t1_idle", busy, 1'b0);

        for (int i = 0; i < 25; i++) v[i] = 8'h00;
        v[0] = 8'd2;
        v[4] = 8'd3;
        v[8] = 8'd4;
        load(3, v, 1'b1, 18, "t2");
        chk_m("t2_pack", matrix_out, 200'h04000000000003000000000002);
        det = el(0, 0) * (el(1, 1) * el(2, 2) - el(1, 2) * el(2, 1))
            - el(0, 1) * (el(1, 0) * el(2, 2) - el(1, 2) * el(2, 0))
            + el(0, 2) * (el(1, 0) * el(2, 1) - el(1, 1) * el(2, 0));
        chk_m("t2_det", MW'(det), MW'(24));
        ack();

        for (int i = 0; i < 25; i++) v[i] = 8'(i + 1);
        load(5, v, 1'b0, 26, "t3");
        chk_m("t3_last", MW'(matrix_out[199:192]), MW'(8'h19));
        snap = matrix_out;
        repeat (5) begin
            step();
            chk_m("t3_hold", matrix_out, snap);
            chk_b("t3_ready", in_ready, 1'b0);
        end
        ack();

        snap  = matrix_out;
        start = 1'b1;
        size  = 3'd0;
        step();
        start = 1'b0;
        chk_b("err0_pulse", size_err, 1'b1);
        chk_b("err0_busy", busy, 1'b0);
        step();
        chk_b("err0_end", size_err, 1'b0);
        start = 1'b1;
        size  = 3'd6;
        step();
        start = 1'b0;
        chk_b("err6_pulse", size_err, 1'b1);
        chk_b("err6_busy", busy, 1'b0);
        step();
        chk_b("err6_end", size_err, 1'b0);
        chk_m("err_matrix", matrix_out, snap);

        start = 1'b1;
        size  = 3'd3;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(i + 1);
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        chk_b("rst2_busy", busy, 1'b0);
        chk_b("rst2_ready", in_ready, 1'b0);
        chk_b("rst2_valid", matrix_valid, 1'b0);
        chk_m("rst2_matrix", matrix_out, '0);
        v[0] = 8'd5;
        v[1] = 8'd6;
        v[2] = 8'd7;
        v[3] = 8'd8;
        load(2, v, 1'b0, 5, "t5");
        chk_m("t5_pack", matrix_out, 200'h08070000000605);
        ack();

        for (int i = 0; i < 4; i++) v[i] = 8'(i + 1);
        load(2, v, 1'b0, 5, "t6a");
        matrix_ack = 1'b1;
        start      = 1'b1;
        size       = 3'd2;
        step();
        matrix_ack = 1'b0;
        chk_b("t6_idle_busy", busy, 1'b0);
        chk_b("t6_idle_ready", in_ready, 1'b0);
        step();
        start = 1'b0;
        chk_b("t6_load_busy", busy, 1'b1);
        chk_b("t6_load_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) v[i] = 8'(i + 9);
        feed(2, v, 1'b0);
        chk_b("t6_valid", matrix_valid, 1'b1);
        chk_m("t6_pack", matrix_out, 200'h0C0B0000000A09);
        ack();
        step();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
